// File: rtl/exe_stage_unit.sv
// Execute stage: single-cycle ALU, NZCV status, branch resolution, registered EX/MEM bundle.
// Define EXE_MUL_EN to build the iterative 32-cycle multiplier and its BUSY state.
module exe_stage_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [2:0]  exe_cmd,
    input  logic [31:0] rn_val,
    input  logic [31:0] rm_val,
    input  logic [31:0] sign_ext,
    input  logic        alu_src,
    input  logic [31:0] next_pc,
    input  logic [25:0] signed_imm_24,
    input  logic        b,
    input  logic        s,
    input  logic        wb_en,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [4:0]  dest,
    output logic        freeze,
    output logic        flush,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        out_valid,
    output logic [31:0] alu_result,
    output logic [31:0] store_data,
    output logic [4:0]  dest_out,
    output logic        wb_en_out,
    output logic        mem_r_out,
    output logic        mem_w_out,
    output logic [3:0]  status
);

    localparam logic [2:0] CMD_ADD = 3'b000;
    localparam logic [2:0] CMD_SUB = 3'b001;
    localparam logic [2:0] CMD_AND = 3'b010;
    localparam logic [2:0] CMD_ORR = 3'b011;
    localparam logic [2:0] CMD_EOR = 3'b100;
    localparam logic [2:0] CMD_MOV = 3'b101;
    localparam logic [2:0] CMD_MVN = 3'b110;
    localparam logic [2:0] CMD_MUL = 3'b111;

    // ---------------------------------------------------------------- ALU
    logic [31:0] op_b;
    logic [32:0] add_sum;
    logic [32:0] sub_sum;
    logic [31:0] alu_res;
    logic        alu_c;
    logic        alu_v;
    logic        alu_upd_cv;
    logic        is_mul;
    logic        take_branch;

    assign op_b    = alu_src ? sign_ext : rm_val;
    assign add_sum = {1'b0, rn_val} + {1'b0, op_b};
    assign sub_sum = {1'b0, rn_val} + {1'b0, ~op_b} + 33'd1;
    assign is_mul  = (exe_cmd == CMD_MUL);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        alu_res    = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        alu_upd_cv = 1'b0;
        unique case (exe_cmd)
            CMD_ADD: begin
                alu_res    = add_sum[31:0];
                alu_c      = add_sum[32];
                alu_v      = (rn_val[31] == op_b[31]) && (add_sum[31] != rn_val[31]);
                alu_upd_cv = 1'b1;
            end
            CMD_SUB: begin
                alu_res    = sub_sum[31:0];
                alu_c      = sub_sum[32];
                alu_v      = (rn_val[31] != op_b[31]) && (sub_sum[31] != rn_val[31]);
                alu_upd_cv = 1'b1;
            end
            CMD_AND: alu_res = rn_val & op_b;
            CMD_ORR: alu_res = rn_val | op_b;
            CMD_EOR: alu_res = rn_val ^ op_b;
            CMD_MOV: alu_res = op_b;
            CMD_MVN: alu_res = ~op_b;
            CMD_MUL: alu_res = '0;  // the single-cycle path has no multiplier
            default: alu_res = '0;
        endcase
    end

    // Offset is in words: sign-extend, scale by 4, keep the low 32 bits.
    assign branch_target = next_pc + {{4{signed_imm_24[25]}}, signed_imm_24, 2'b00};

    // ---------------------------------------------------------------- multiplier
    logic        busy;
    logic        mul_start;
    logic        mul_done;
    logic        freeze_raw;
    logic [31:0] mul_result;
    logic [4:0]  cap_dest;
    logic        cap_wb_en;
    logic        cap_mem_r;
    logic        cap_mem_w;
    logic        cap_s;
    logic [31:0] cap_store;

`ifdef EXE_MUL_EN
    typedef enum logic {IDLE, BUSY} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] acc_sum;
    logic [4:0]  cap_dest_q, cap_dest_d;
    logic        cap_wb_en_q, cap_wb_en_d;
    logic        cap_mem_r_q, cap_mem_r_d;
    logic        cap_mem_w_q, cap_mem_w_d;
    logic        cap_s_q, cap_s_d;
    logic [31:0] cap_store_q, cap_store_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (mul_start) state_d = BUSY;
            BUSY:    if (mul_done)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == BUSY);
        mul_start  = (state_q == IDLE) && in_valid && is_mul && !b;
        mul_done   = busy && (cnt_q == 5'd31);
        freeze_raw = mul_start || (busy && !mul_done);
    end

    // Only the low 32 bits of the product are kept, so a 32-bit multiplicand suffices.
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

    always_comb begin
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cap_dest_d  = cap_dest_q;
        cap_wb_en_d = cap_wb_en_q;
        cap_mem_r_d = cap_mem_r_q;
        cap_mem_w_d = cap_mem_w_q;
        cap_s_d     = cap_s_q;
        cap_store_d = cap_store_q;
        if (mul_start) begin
            cnt_d       = '0;
            mcand_d     = rn_val;
            mplier_d    = op_b;
            acc_d       = '0;
            cap_dest_d  = dest;
            cap_wb_en_d = wb_en;
            cap_mem_r_d = mem_r;
            cap_mem_w_d = mem_w;
            cap_s_d     = s;
            cap_store_d = rm_val;
        end else if (busy) begin
            cnt_d    = cnt_q + 5'd1;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = acc_sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cap_dest_q  <= '0;
            cap_wb_en_q <= 1'b0;
            cap_mem_r_q <= 1'b0;
            cap_mem_w_q <= 1'b0;
            cap_s_q     <= 1'b0;
            cap_store_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cap_dest_q  <= cap_dest_d;
            cap_wb_en_q <= cap_wb_en_d;
            cap_mem_r_q <= cap_mem_r_d;
            cap_mem_w_q <= cap_mem_w_d;
            cap_s_q     <= cap_s_d;
            cap_store_q <= cap_store_d;
        end
    end

    assign mul_result = acc_sum;
    assign cap_dest   = cap_dest_q;
    assign cap_wb_en  = cap_wb_en_q;
    assign cap_mem_r  = cap_mem_r_q;
    assign cap_mem_w  = cap_mem_w_q;
    assign cap_s      = cap_s_q;
    assign cap_store  = cap_store_q;
`else
    assign busy       = 1'b0;
    assign mul_start  = 1'b0;
    assign mul_done   = 1'b0;
    assign freeze_raw = 1'b0;
    assign mul_result = '0;
    assign cap_dest   = '0;
    assign cap_wb_en  = 1'b0;
    assign cap_mem_r  = 1'b0;
    assign cap_mem_w  = 1'b0;
    assign cap_s      = 1'b0;
    assign cap_store  = '0;
`endif

    // ---------------------------------------------------------------- hazard outputs
    assign take_branch  = !busy && in_valid && b;
    assign branch_taken = take_branch && !rst;
    assign flush        = take_branch && !rst;
    assign freeze       = freeze_raw && !rst;

    // ---------------------------------------------------------------- EX/MEM register
    logic        out_valid_q, out_valid_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] store_data_q, store_data_d;
    logic [4:0]  dest_out_q, dest_out_d;
    logic        wb_en_out_q, wb_en_out_d;
    logic        mem_r_out_q, mem_r_out_d;
    logic        mem_w_out_q, mem_w_out_d;
    logic [3:0]  status_q, status_d;

    always_comb begin
        out_valid_d  = 1'b0;
        alu_result_d = alu_result_q;
        store_data_d = store_data_q;
        dest_out_d   = dest_out_q;
        wb_en_out_d  = 1'b0;
        mem_r_out_d  = 1'b0;
        mem_w_out_d  = 1'b0;
        status_d     = status_q;
        if (mul_done) begin
            out_valid_d  = 1'b1;
            alu_result_d = mul_result;
            store_data_d = cap_store;
            dest_out_d   = cap_dest;
            wb_en_out_d  = cap_wb_en;
            mem_r_out_d  = cap_mem_r;
            mem_w_out_d  = cap_mem_w;
            if (cap_s) status_d[3:2] = {mul_result[31], mul_result == 32'd0};
        end else if (!busy && in_valid && !mul_start) begin
            out_valid_d  = 1'b1;
            alu_result_d = alu_res;
            store_data_d = rm_val;
            dest_out_d   = dest;
            // A taken branch retires with no side effects and leaves the flags alone.
            if (!take_branch) begin
                wb_en_out_d = wb_en;
                mem_r_out_d = mem_r;
                mem_w_out_d = mem_w;
                if (s) begin
                    status_d[3:2] = {alu_res[31], alu_res == 32'd0};
                    if (alu_upd_cv) status_d[1:0] = {alu_c, alu_v};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            alu_result_q <= '0;
            store_data_q <= '0;
            dest_out_q   <= '0;
            wb_en_out_q  <= 1'b0;
            mem_r_out_q  <= 1'b0;
            mem_w_out_q  <= 1'b0;
            status_q     <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            alu_result_q <= alu_result_d;
            store_data_q <= store_data_d;
            dest_out_q   <= dest_out_d;
            wb_en_out_q  <= wb_en_out_d;
            mem_r_out_q  <= mem_r_out_d;
            mem_w_out_q  <= mem_w_out_d;
            status_q     <= status_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign alu_result = alu_result_q;
    assign store_data = store_data_q;
    assign dest_out   = dest_out_q;
    assign wb_en_out  = wb_en_out_q;
    assign mem_r_out  = mem_r_out_q;
    assign mem_w_out  = mem_w_out_q;
    assign status     = status_q;

endmodule

// File: tb/tb_exe_stage_unit.sv
// Directed bench for exe_stage_unit: ALU vector table, then branch, multiply and reset sequences.
module tb_exe_stage_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [2:0]  exe_cmd;
    logic [31:0] rn_val, rm_val, sign_ext, next_pc;
    logic        alu_src, b, s, wb_en, mem_r, mem_w;
    logic [25:0] signed_imm_24;
    logic [4:0]  dest;
    logic        freeze, flush, branch_taken, out_valid;
    logic [31:0] branch_target, alu_result, store_data;
    logic [4:0]  dest_out;
    logic        wb_en_out, mem_r_out, mem_w_out;
    logic [3:0]  status;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    exe_stage_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .exe_cmd(exe_cmd),
        .rn_val(rn_val), .rm_val(rm_val), .sign_ext(sign_ext), .alu_src(alu_src),
        .next_pc(next_pc), .signed_imm_24(signed_imm_24), .b(b), .s(s),
        .wb_en(wb_en), .mem_r(mem_r), .mem_w(mem_w), .dest(dest),
        .freeze(freeze), .flush(flush), .branch_taken(branch_taken),
        .branch_target(branch_target), .out_valid(out_valid), .alu_result(alu_result),
        .store_data(store_data), .dest_out(dest_out), .wb_en_out(wb_en_out),
        .mem_r_out(mem_r_out), .mem_w_out(mem_w_out), .status(status)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    endtask

    typedef struct {
        logic [2:0]  cmd;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [31:0] imm;
        logic        src;
        logic        s;
        logic [2:0]  ctl;       // {wb_en, mem_r, mem_w}
        logic [4:0]  dst;
        logic [31:0] exp_res;
        logic [3:0]  exp_nzcv;
    } vec_t;

    vec_t vecs[11];

    task automatic idle_inputs();
        in_valid = 0; exe_cmd = 0; rn_val = 0; rm_val = 0; sign_ext = 0; alu_src = 0;
        next_pc = 0; signed_imm_24 = 0; b = 0; s = 0; wb_en = 0; mem_r = 0; mem_w = 0; dest = 0;
    endtask

    initial begin
        int freeze_cnt;
        int first_low;
        int done_cycle;
        logic [31:0] exp_mul;
        logic [3:0]  exp_mul_st;

        // Status flags chain from one vector to the next.
        vecs[0]  = '{3'b000, 32'h7FFFFFFF, 32'h1,        32'h0,    1'b0, 1'b1, 3'b100, 5'd1,  32'h80000000, 4'b1001};
        vecs[1]  = '{3'b001, 32'h5,        32'h9,        32'h5,    1'b1, 1'b1, 3'b100, 5'd2,  32'h0,        4'b0110};
        vecs[2]  = '{3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,    1'b0, 1'b1, 3'b010, 5'd3,  32'h00F000F0, 4'b0010};
        vecs[3]  = '{3'b011, 32'h80000000, 32'h1,        32'h0,    1'b0, 1'b0, 3'b001, 5'd4,  32'h80000001, 4'b0010};
        vecs[4]  = '{3'b100, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,    1'b0, 1'b1, 3'b100, 5'd5,  32'h0,        4'b0110};
        vecs[5]  = '{3'b101, 32'h0,        32'hDEAD,     32'h1234, 1'b1, 1'b1, 3'b100, 5'd6,  32'h1234,     4'b0010};
        vecs[6]  = '{3'b110, 32'h0,        32'h0,        32'h0,    1'b0, 1'b1, 3'b100, 5'd7,  32'hFFFFFFFF, 4'b1010};
        vecs[7]  = '{3'b000, 32'hFFFFFFFF, 32'h1,        32'h0,    1'b0, 1'b1, 3'b100, 5'd8,  32'h0,        4'b0110};
        vecs[8]  = '{3'b001, 32'h0,        32'h1,        32'h0,    1'b0, 1'b1, 3'b100, 5'd9,  32'hFFFFFFFF, 4'b1000};
        vecs[9]  = '{3'b001, 32'h80000000, 32'h1,        32'h0,    1'b0, 1'b1, 3'b100, 5'd10, 32'h7FFFFFFF, 4'b0011};
        vecs[10] = '{3'b000, 32'h80000000, 32'h80000000, 32'h0,    1'b0, 1'b1, 3'b100, 5'd11, 32'h0,        4'b0111};

        // ---------------- reset
        idle_inputs();
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 0;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_alu_result", alu_result, 0);
        check("rst_store_data", store_data, 0);
        check("rst_dest_out", {27'b0, dest_out}, 0);
        check("rst_ctl", {29'b0, wb_en_out, mem_r_out, mem_w_out}, 0);
        check("rst_status", {28'b0, status}, 0);
        check("rst_hazards", {29'b0, freeze, flush, branch_taken}, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_out_valid", {31'b0, out_valid}, 0);
        end

        // ---------------- ALU table
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            in_valid = 1; exe_cmd = vecs[i].cmd; rn_val = vecs[i].rn; rm_val = vecs[i].rm;
            sign_ext = vecs[i].imm; alu_src = vecs[i].src; s = vecs[i].s;
            {wb_en, mem_r, mem_w} = vecs[i].ctl; dest = vecs[i].dst;
            #1;
            check($sformatf("v%0d_freeze", i), {31'b0, freeze}, 0);
            @(posedge clk); #1;
            idle_inputs();
            check($sformatf("v%0d_valid", i), {31'b0, out_valid}, 1);
            check($sformatf("v%0d_result", i), alu_result, vecs[i].exp_res);
            check($sformatf("v%0d_status", i), {28'b0, status}, {28'b0, vecs[i].exp_nzcv});
            check($sformatf("v%0d_ctl", i), {29'b0, wb_en_out, mem_r_out, mem_w_out}, {29'b0, vecs[i].ctl});
            check($sformatf("v%0d_dest", i), {27'b0, dest_out}, {27'b0, vecs[i].dst});
            check($sformatf("v%0d_store", i), store_data, vecs[i].rm);
        end
        @(posedge clk); #1;
        check("bubble_valid", {31'b0, out_valid}, 0);
        check("bubble_ctl", {29'b0, wb_en_out, mem_r_out, mem_w_out}, 0);

        // ---------------- branch (flags must stay 0111)
        in_valid = 1; b = 1; next_pc = 32'h100; signed_imm_24 = 26'h3FFFFFE;
        wb_en = 1; mem_w = 1; s = 1; exe_cmd = 3'b000; rn_val = 0; rm_val = 0;
        #1;
        check("br_flush", {31'b0, flush}, 1);
        check("br_taken", {31'b0, branch_taken}, 1);
        check("br_target", branch_target, 32'hF8);
        check("br_freeze", {31'b0, freeze}, 0);
        @(posedge clk); #1;
        idle_inputs();
        #1;
        check("br_valid", {31'b0, out_valid}, 1);
        check("br_ctl", {29'b0, wb_en_out, mem_r_out, mem_w_out}, 0);
        check("br_status", {28'b0, status}, 32'h7);
        check("br_flush_gone", {31'b0, flush}, 0);

        // ---------------- multiply, presented in cycle 0
        @(posedge clk); #1;
        in_valid = 1; exe_cmd = 3'b111; rn_val = 32'h12345; rm_val = 32'h100;
        s = 1; wb_en = 1; dest = 5'd7;
`ifdef EXE_MUL_EN
        exp_mul = 32'h01234500; exp_mul_st = 4'b0011;
`else
        exp_mul = 32'h0; exp_mul_st = 4'b0111;
`endif
        freeze_cnt = 0; first_low = -1; done_cycle = -1;
        for (int c = 0; c < 40 && done_cycle < 0; c++) begin
            logic drop;
            @(negedge clk);
            drop = 0;
            if (freeze) freeze_cnt++;
            else if (first_low < 0) begin first_low = c; drop = 1; end
            if (c > 0 && out_valid) begin
                done_cycle = c;
                check("mul_result", alu_result, exp_mul);
                check("mul_status", {28'b0, status}, {28'b0, exp_mul_st});
                check("mul_wb_dest", {26'b0, wb_en_out, dest_out}, {26'b0, 1'b1, 5'd7});
                check("mul_store", store_data, 32'h100);
            end
            @(posedge clk); #1;
            if (drop) idle_inputs();
        end
`ifdef EXE_MUL_EN
        check("mul_freeze_cycles", freeze_cnt, 32);
        check("mul_freeze_low", first_low, 32);
        check("mul_done_cycle", done_cycle, 33);
`else
        check("mul_freeze_cycles", freeze_cnt, 0);
        check("mul_done_cycle", done_cycle, 1);
`endif

        // ---------------- reset in cycle 10 of a multiply
        idle_inputs();
        @(posedge clk); #1;
        in_valid = 1; exe_cmd = 3'b111; rn_val = 32'h3; rm_val = 32'h3; s = 1;
        repeat (10) @(posedge clk);
        #1;
        rst = 1;
        #1;
        check("rstmul_freeze", {31'b0, freeze}, 0);
        check("rstmul_valid", {31'b0, out_valid}, 0);
        check("rstmul_status", {28'b0, status}, 0);
        idle_inputs();
        @(negedge clk) rst = 0;
        @(posedge clk); #1;
        in_valid = 1; exe_cmd = 3'b000; rn_val = 2; rm_val = 3; wb_en = 1;
        @(posedge clk); #1;
        idle_inputs();
        check("post_rst_valid", {31'b0, out_valid}, 1);
        check("post_rst_result", alu_result, 5);
        check("post_rst_status", {28'b0, status}, 0);
        @(posedge clk); #1;
        check("post_rst_idle", {31'b0, out_valid}, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
